// File: rtl/aclk_time_counter_pkg.sv
// +-----------------------------------------------------------------------+
// | aclk_time_counter_pkg : BCD digit widths and wrap constants            |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package aclk_time_counter_pkg;

    localparam int MS_HR_W  = 2;
    localparam int LS_HR_W  = 4;
    localparam int MS_MIN_W = 3;
    localparam int LS_MIN_W = 4;

    localparam int HOUR_MAX_DEF = 23;
    localparam int MIN_MAX_DEF  = 59;

    // Rollover points: units digits, minute tens, and the 2x:3 hour boundary.
    localparam int UNITS_WRAP  = 9;
    localparam int MS_MIN_WRAP = 5;
    localparam int MS_HR_WRAP  = 2;
    localparam int LS_HR_WRAP  = 3;

    function automatic logic bcd_ok(input logic [3:0] d);
        return d <= 4'(UNITS_WRAP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aclk_time_counter_if.sv
// +-----------------------------------------------------------------------+
// | aclk_time_counter_if : advance/load strobes and current-time bus       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface aclk_time_counter_if;
    import aclk_time_counter_pkg::*;

    logic                  one_minute;
    logic                  load_new_c;
    logic [MS_HR_W-1:0]    new_ms_hr;
    logic [LS_HR_W-1:0]    new_ls_hr;
    logic [MS_MIN_W-1:0]   new_ms_min;
    logic [LS_MIN_W-1:0]   new_ls_min;
    logic [MS_HR_W-1:0]    cur_ms_hr;
    logic [LS_HR_W-1:0]    cur_ls_hr;
    logic [MS_MIN_W-1:0]   cur_ms_min;
    logic [LS_MIN_W-1:0]   cur_ls_min;
    logic                  day_tick;
    logic                  load_err;

    modport master (
        output one_minute, load_new_c, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
        input  cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min, day_tick, load_err
    );

    modport slave (
        input  one_minute, load_new_c, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
        output cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min, day_tick, load_err
    );

endinterface

`default_nettype wire

// File: rtl/aclk_bcd_digit.sv
// +-----------------------------------------------------------------------+
// | aclk_bcd_digit : single loadable digit counter with wrap and carry     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module aclk_bcd_digit #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             inc,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic [WIDTH-1:0] wrap_at,
    output logic      [WIDTH-1:0] value,
    output logic                  carry
);

    // >= rather than == so a digit can never run past its wrap point.
    assign carry = inc && (value >= wrap_at);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= carry ? '0 : value + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aclk_time_counter.sv
// +-----------------------------------------------------------------------+
// | aclk_time_counter : HH:MM BCD time of day, advanced by one_minute      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module aclk_time_counter
    import aclk_time_counter_pkg::*;
#(
    parameter int HOUR_MAX = HOUR_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    aclk_time_counter_if.slave bus
);

    localparam logic [MS_HR_W-1:0]  MS_HR_TOP  = MS_HR_W'(HOUR_MAX / 10);
    localparam logic [LS_HR_W-1:0]  LS_HR_TOP  = LS_HR_W'(HOUR_MAX % 10);
    localparam logic [MS_MIN_W-1:0] MS_MIN_TOP = MS_MIN_W'(MIN_MAX / 10);
    localparam logic [LS_MIN_W-1:0] LS_MIN_TOP = LS_MIN_W'(MIN_MAX % 10);
    localparam logic [LS_HR_W-1:0]  UNITS_TOP  = LS_HR_W'(UNITS_WRAP);

    logic                load_ok;
    logic                load_dig;
    logic                advance;
    logic [LS_MIN_W-1:0] wrap_ls_min;
    logic [LS_HR_W-1:0]  wrap_ls_hr;
    logic                carry_ls_min;
    logic                carry_ms_min;
    logic                carry_ls_hr;
    logic                carry_ms_hr;

    always_comb begin
        load_ok = bcd_ok(bus.new_ls_hr) && bcd_ok(bus.new_ls_min)
               && ((int'(bus.new_ms_hr) * 10 + int'(bus.new_ls_hr)) <= HOUR_MAX)
               && ((int'(bus.new_ms_min) * 10 + int'(bus.new_ls_min)) <= MIN_MAX);
    end

    // A load, valid or not, swallows any coincident advance.
    assign load_dig = bus.load_new_c && load_ok;
    assign advance  = bus.one_minute && !bus.load_new_c;

    // Units digits wrap early only when their tens digit sits at the top value.
    assign wrap_ls_min = (bus.cur_ms_min == MS_MIN_TOP) ? LS_MIN_TOP : UNITS_TOP;
    assign wrap_ls_hr  = (bus.cur_ms_hr  == MS_HR_TOP)  ? LS_HR_TOP  : UNITS_TOP;

    aclk_bcd_digit #(.WIDTH(LS_MIN_W)) u_ls_min (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (advance),
        .load     (load_dig),
        .load_val (bus.new_ls_min),
        .wrap_at  (wrap_ls_min),
        .value    (bus.cur_ls_min),
        .carry    (carry_ls_min)
    );

    aclk_bcd_digit #(.WIDTH(MS_MIN_W)) u_ms_min (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (carry_ls_min),
        .load     (load_dig),
        .load_val (bus.new_ms_min),
        .wrap_at  (MS_MIN_TOP),
        .value    (bus.cur_ms_min),
        .carry    (carry_ms_min)
    );

    aclk_bcd_digit #(.WIDTH(LS_HR_W)) u_ls_hr (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (carry_ms_min),
        .load     (load_dig),
        .load_val (bus.new_ls_hr),
        .wrap_at  (wrap_ls_hr),
        .value    (bus.cur_ls_hr),
        .carry    (carry_ls_hr)
    );

    aclk_bcd_digit #(.WIDTH(MS_HR_W)) u_ms_hr (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (carry_ls_hr),
        .load     (load_dig),
        .load_val (bus.new_ms_hr),
        .wrap_at  (MS_HR_TOP),
        .value    (bus.cur_ms_hr),
        .carry    (carry_ms_hr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.day_tick <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.day_tick <= carry_ms_hr;
            bus.load_err <= bus.load_new_c && !load_ok;
        end
    end

endmodule

`default_nettype wire

// File: doc/aclk_time_counter.md
# aclk_time_counter

Downstream consumer of the alarm-clock time generator's `one_minute` pulse. Keeps the current time of day as four BCD digits (HH:MM, 24-hour, 00:00–23:59) and advances it by one minute per pulse. Accepts a synchronous load of a user-set time from the keypad/FSM path and emits a day-rollover pulse. Outputs feed the alarm comparator and the display driver.

## Interface

Parameters:
- `HOUR_MAX`, default 23: last valid hour before wrap to 00.
- `MIN_MAX`, default 59: last valid minute before wrap to 00.

Ports:
- `clk`  in  1  system clock; same domain as the time generator.
- `reset_n`  in  1  asynchronous, active-low reset.
- `one_minute`  in  1  single-cycle advance strobe from the time generator.
- `load_new_c`  in  1  load strobe for a user-set time.
- `new_ms_hr`  in  2  load value, hour tens digit.
- `new_ls_hr`  in  4  load value, hour units digit.
- `new_ms_min`  in  3  load value, minute tens digit.
- `new_ls_min`  in  4  load value, minute units digit.
- `cur_ms_hr`  out  2  current hour tens, BCD.
- `cur_ls_hr`  out  4  current hour units, BCD.
- `cur_ms_min`  out  3  current minute tens, BCD.
- `cur_ls_min`  out  4  current minute units, BCD.
- `day_tick`  out  1  one-cycle pulse on 23:59 → 00:00 rollover.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation

- Reset (`reset_n` low, async): all `cur_*` = 0 (00:00), `day_tick` = 0, `load_err` = 0. Counting resumes on the first `clk` edge after `reset_n` deasserts.
- Priority per edge: reset > load > advance > hold.
- Load (`load_new_c` = 1): a load is valid when every digit is ≤ 9, `new_ms_min` ≤ 5, and the hour value is ≤ `HOUR_MAX` (for 23: ms_hr ≤ 2, and ls_hr ≤ 3 when ms_hr = 2).
  - Valid load: all four digits take the new value. `load_err` = 0.
  - Invalid load: the time is unchanged. `load_err` pulses 1.
  - A `one_minute` arriving on the same edge as a load is dropped in both cases.
- Advance (`one_minute` = 1, no load): BCD cascade.
  - ls_min 9 → 0 and carry. ms_min 5 → 0 and carry.
  - ls_hr 9 → 0 and carry into ms_hr. When the hour = `HOUR_MAX` and the minute carries out, the hour becomes 00.
  - 23:59 → 00:00 asserts `day_tick` for exactly that cycle.
- `one_minute` held high for N cycles advances N minutes. There is no edge detection, because the generator guarantees single-cycle pulses.
- `day_tick` and `load_err` are 0 in every cycle that does not meet their condition above.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- Latency: an input sampled at edge k is reflected on the outputs after edge k, in cycle k+1.
- `day_tick` and `load_err` are valid in the same cycle as the updated time.
- Back-to-back pulses on consecutive cycles are each honoured. There is no dead cycle.
- An async reset in mid-cascade (for example, on the 23:59 edge) wins. Outputs return to 00:00 and no `day_tick` is emitted.

## Structure

- Shared header `aclk_defs` holds:
  - BCD digit widths (2/4/3/4).
  - Limits `HOUR_MAX`/`MIN_MAX`.
  - Rollover constants: 9 for units, 5 for minute tens, 2/3 for the hour boundary.
  - The same header is used by the alarm register and the display driver.
- One natural sub-module: `aclk_bcd_digit`, a parameterised single-digit counter.
  - Inputs: `inc`, `load`, `load_val`, `wrap_at`.
  - Outputs: the digit value and `carry`.
  - Four instances are chained.
  - The hour pair needs extra wrap logic at 23, kept in the top level.
- Load validation is a combinational checker in the top level. It gates `load` to all four digits.
- Expected size is about 150–250 lines of RTL.

## Test plan

1. Reset: drive `reset_n` = 0 mid-count at 12:34. Outputs go to 00:00 asynchronously, with `day_tick` = `load_err` = 0.
2. Cascade: load 09:59, then one `one_minute` → 10:00. Load 19:59, then one pulse → 20:00.
3. Day wrap: load 23:59, then one pulse → 00:00 with `day_tick` = 1 for exactly one cycle. A further pulse → 00:01 with `day_tick` = 0.
4. Invalid loads: each of 24:00, 2A:00, 12:60 and 12:5F leaves the current time unchanged and pulses `load_err` once.
5. Simultaneous events: at 10:10, assert `load_new_c` = 1 with value 05:30 together with `one_minute` = 1 → 05:30, not 05:31. An invalid load with a simultaneous pulse keeps 10:10 and pulses `load_err`.
6. Throughput: from 00:00, apply 1440 consecutive single-cycle pulses → back at 00:00 with exactly one `day_tick`. A check against a reference minute count passes after every pulse.
